// File: rtl/nibble_serial_add_ctrl_pkg.sv
// nsa_pkg: shared definitions for the nibble-serial add/subtract controller.
// Holds the FSM state encoding and the helper that sizes the nibble index.
package nsa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Index width for nib nibbles: max(1, clog2(nib)).
  function automatic int idx_bits(input int nib);
    int r;
    r = 0;
    while ((1 << r) < nib) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/nibble_serial_add_ctrl_if.sv
// nsa_if: request/response bus of the nibble-serial adder.
//   master: drives in_valid/in_a/in_b/in_sub/in_cin and out_ready.
//   slave : drives in_ready and out_valid/out_sum/out_cout/out_ovf.
// Handshake: a transfer happens on a rising clk edge where valid && ready
// are both high; the sender holds its payload stable while valid && !ready.
interface nsa_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_sub, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/nibble_serial_add_ctrl_adder4.sv
// adder4: 4-bit carry-lookahead adder.
//   a, b : 4-bit operands      cin  : carry in
//   sum  : 4-bit sum           cout : carry out
module adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is a flat function of g/p/cin: no ripple inside the nibble.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];
endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: WIDTH-bit add/subtract computed one nibble per
// cycle (LSB nibble first) through a single adder4.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : nsa_if slave (operand request / result response)
//   busy       : high while an operation is in RUN or DONE
//   state_dbg  : current FSM state
module nibble_serial_add_ctrl
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic   clk,
  input  logic   rst_n,
  nsa_if.slave   bus,
  output logic   busy,
  output state_t state_dbg
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = idx_bits(NIB);
  localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

  if ((WIDTH % 4 != 0) || (WIDTH < 8)) begin : g_bad_width
    $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 8");
  end

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             cout_q, ovf_q;

  logic [3:0] a_nib, b_nib, s_nib;
  logic       c_nib;
  logic       accept, last;

  assign accept = bus.in_valid && (state_q == ST_IDLE);
  assign last   = (idx_q == LAST_IDX);

  // Nibble select for the adder inputs.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIB; i++) begin
      if (idx_q == IW'(i)) begin
        a_nib = a_q[4*i +: 4];
        b_nib = b_q[4*i +: 4];
      end
    end
  end

  adder4 u_adder4 (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_q),
    .sum  (s_nib),
    .cout (c_nib)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.in_valid) state_d = ST_RUN;
      ST_RUN:  if (last)         state_d = ST_DONE;
      ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        // Subtract is A + ~B + 1, so B is inverted once here and the +1
        // enters as the initial carry.
        a_q     <= bus.in_a;
        b_q     <= bus.in_sub ? ~bus.in_b : bus.in_b;
        carry_q <= bus.in_sub ? 1'b1 : bus.in_cin;
        idx_q   <= '0;
        sum_q   <= '0;
      end else if (state_q == ST_RUN) begin
        for (int i = 0; i < NIB; i++) begin
          if (idx_q == IW'(i)) sum_q[4*i +: 4] <= s_nib;
        end
        carry_q <= c_nib;
        idx_q   <= last ? '0 : idx_q + IW'(1);
        if (last) begin
          cout_q <= c_nib;
          // Overflow: operands (after B inversion) share a sign that the
          // result does not.
          ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (s_nib[3] != a_q[WIDTH-1]);
        end
      end
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = cout_q;
  assign bus.out_ovf   = ovf_q;
  assign busy          = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign state_dbg     = state_q;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Bench for nibble_serial_add_ctrl: a 16-bit and a 32-bit instance, a
// table of directed vectors, hand-written stall/reset sequences and a
// random back-to-back phase checked through per-instance scoreboards.
module tb_nibble_serial_add_ctrl;
  import nsa_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nsa_if #(.WIDTH(16)) if16 ();
  nsa_if #(.WIDTH(32)) if32 ();
  logic   busy16, busy32;
  state_t st16, st32;

  nibble_serial_add_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(if16.slave), .busy(busy16), .state_dbg(st16)
  );
  nibble_serial_add_ctrl #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .bus(if32.slave), .busy(busy32), .state_dbg(st32)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [33:0] exp16_q[$];
  logic [33:0] exp32_q[$];
  int unsigned acc16_cyc = 0, acc32_cyc = 0;
  int done16 = 0, done32 = 0;
  logic pv16 = 1'b0, pv32 = 1'b0;
  logic [15:0] last_sum16 = '0;
  logic last_cout16 = 1'b0, last_ovf16 = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain wide arithmetic, result packed as {cout, ovf, sum}.
  function automatic logic [33:0] model(input int w, input logic [31:0] a,
                                        input logic [31:0] b, input logic sub,
                                        input logic cin);
    logic [32:0] mask, full;
    logic [31:0] am, bb, s;
    logic co, ov;
    mask = (33'd1 << w) - 33'd1;
    am   = a & mask[31:0];
    bb   = (sub ? ~b : b) & mask[31:0];
    full = {1'b0, am} + {1'b0, bb} + {32'd0, (sub ? 1'b1 : cin)};
    s    = full[31:0] & mask[31:0];
    co   = full[w];
    ov   = (am[w-1] == bb[w-1]) && (s[w-1] != am[w-1]);
    return {co, ov, s};
  endfunction

  // Monitors sample at the falling edge; a handshake seen there completes
  // on the next rising edge.
  always @(negedge clk) begin
    logic [33:0] e;
    if (!rst_n) begin
      exp16_q.delete();
      pv16 = 1'b0;
    end else begin
      if (if16.out_valid && !pv16) check("lat16", 64'(cyc - acc16_cyc), 64'd4);
      pv16 = if16.out_valid;
      if (if16.out_valid && if16.out_ready) begin
        if (exp16_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL res16: unexpected result %0h, expected none", if16.out_sum);
        end else begin
          e = exp16_q.pop_front();
          check("sum16", 64'(if16.out_sum), 64'(e[15:0]));
          check("cout16", 64'(if16.out_cout), 64'(e[33]));
          check("ovf16", 64'(if16.out_ovf), 64'(e[32]));
          last_sum16  = if16.out_sum;
          last_cout16 = if16.out_cout;
          last_ovf16  = if16.out_ovf;
          done16++;
        end
      end
      if (if16.in_valid && if16.in_ready) begin
        exp16_q.push_back(model(16, {16'd0, if16.in_a}, {16'd0, if16.in_b},
                                if16.in_sub, if16.in_cin));
        acc16_cyc = cyc + 1;
      end
    end
  end

  always @(negedge clk) begin
    logic [33:0] e;
    if (!rst_n) begin
      exp32_q.delete();
      pv32 = 1'b0;
    end else begin
      if (if32.out_valid && !pv32) check("lat32", 64'(cyc - acc32_cyc), 64'd8);
      pv32 = if32.out_valid;
      if (if32.out_valid && if32.out_ready) begin
        if (exp32_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL res32: unexpected result %0h, expected none", if32.out_sum);
        end else begin
          e = exp32_q.pop_front();
          check("sum32", 64'(if32.out_sum), 64'(e[31:0]));
          check("cout32", 64'(if32.out_cout), 64'(e[33]));
          check("ovf32", 64'(if32.out_ovf), 64'(e[32]));
          done32++;
        end
      end
      if (if32.in_valid && if32.in_ready) begin
        exp32_q.push_back(model(32, if32.in_a, if32.in_b, if32.in_sub, if32.in_cin));
        acc32_cyc = cyc + 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_valid16(input string name);
    int w = 0;
    @(negedge clk);
    while (!if16.out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    check(name, 64'(if16.out_valid), 64'd1);
  endtask

  // One full operation on the 16-bit instance with out_ready held high.
  task automatic run_op16(input logic [15:0] a, input logic [15:0] b,
                          input logic sub, input logic cin);
    int w = 0;
    @(posedge clk); #1;
    if16.in_valid = 1'b1; if16.in_a = a; if16.in_b = b;
    if16.in_sub = sub; if16.in_cin = cin; if16.out_ready = 1'b1;
    @(negedge clk);
    while (!if16.in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("accept16", 64'(if16.in_ready), 64'd1);
    @(posedge clk); #1;
    if16.in_valid = 1'b0;
    if16.in_a = 16'($urandom);
    if16.in_b = 16'($urandom);
    wait_valid16("valid16_seen");
    @(negedge clk);
    check("valid16_one_cycle", 64'(if16.out_valid), 64'd0);
  endtask

  typedef struct {
    logic [15:0] a, b;
    logic        sub, cin;
    logic [15:0] sum;
    logic        cout, ovf;
  } vec_t;
  vec_t tbl[8];

  initial begin
    #300000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    int d0;
    tbl[0] = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0};
    tbl[3] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    tbl[4] = '{16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[6] = '{16'h1234, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[7] = '{16'hABCD, 16'h1111, 1'b0, 1'b1, 16'hBCDF, 1'b0, 1'b0};

    if16.in_valid = 1'b0; if16.in_a = '0; if16.in_b = '0;
    if16.in_sub = 1'b0; if16.in_cin = 1'b0; if16.out_ready = 1'b1;
    if32.in_valid = 1'b0; if32.in_a = '0; if32.in_b = '0;
    if32.in_sub = 1'b0; if32.in_cin = 1'b0; if32.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready16", 64'(if16.in_ready), 64'd1);
    check("rst_out_valid16", 64'(if16.out_valid), 64'd0);
    check("rst_busy16", 64'(busy16), 64'd0);
    check("rst_sum16", 64'(if16.out_sum), 64'd0);
    check("rst_flags16", 64'({if16.out_cout, if16.out_ovf}), 64'd0);
    check("rst_state16", 64'(st16), 64'(ST_IDLE));
    check("rst_in_ready32", 64'(if32.in_ready), 64'd1);
    check("rst_out_valid32", 64'(if32.out_valid), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      d0 = done16;
      run_op16(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].cin);
      check($sformatf("tbl%0d_done", i), 64'(done16 - d0), 64'd1);
      check($sformatf("tbl%0d_sum", i), 64'(last_sum16), 64'(tbl[i].sum));
      check($sformatf("tbl%0d_cout", i), 64'(last_cout16), 64'(tbl[i].cout));
      check($sformatf("tbl%0d_ovf", i), 64'(last_ovf16), 64'(tbl[i].ovf));
    end

    // Output stall with in_valid held high on other data
    d0 = done16;
    @(posedge clk); #1;
    if16.out_ready = 1'b0; if16.in_valid = 1'b1;
    if16.in_a = 16'h7FFF; if16.in_b = 16'h0001; if16.in_sub = 1'b0; if16.in_cin = 1'b0;
    @(negedge clk);
    check("stall_accept", 64'(if16.in_ready), 64'd1);
    @(posedge clk); #1;
    if16.in_a = 16'h5555; if16.in_b = 16'hAAAA; if16.in_sub = 1'b1; if16.in_cin = 1'b1;
    @(negedge clk);
    check("stall_in_ready_run", 64'(if16.in_ready), 64'd0);
    wait_valid16("stall_valid");
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        @(negedge clk);
      end
      check($sformatf("stall%0d_valid", k), 64'(if16.out_valid), 64'd1);
      check($sformatf("stall%0d_sum", k), 64'(if16.out_sum), 64'h8000);
      check($sformatf("stall%0d_ovf", k), 64'(if16.out_ovf), 64'd1);
      check($sformatf("stall%0d_cout", k), 64'(if16.out_cout), 64'd0);
      check($sformatf("stall%0d_in_ready", k), 64'(if16.in_ready), 64'd0);
    end
    @(posedge clk); #1;
    if16.out_ready = 1'b1; if16.in_valid = 1'b0;
    @(negedge clk);
    check("stall_release_state", 64'(st16), 64'(ST_DONE));
    @(negedge clk);
    check("stall_idle_state", 64'(st16), 64'(ST_IDLE));
    check("stall_idle_ready", 64'(if16.in_ready), 64'd1);
    check("stall_idle_busy", 64'(busy16), 64'd0);
    check("stall_one_result", 64'(done16 - d0), 64'd1);
    check("stall_result_sum", 64'(last_sum16), 64'h8000);

    // Reset in the middle of RUN
    @(posedge clk); #1;
    if16.in_valid = 1'b1; if16.in_a = 16'hFFFF; if16.in_b = 16'hFFFF;
    if16.in_sub = 1'b0; if16.in_cin = 1'b0;
    @(negedge clk);
    check("rr_accept", 64'(if16.in_ready), 64'd1);
    @(posedge clk); #1;
    if16.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    check("rr_busy_before", 64'(busy16), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rr_out_valid", 64'(if16.out_valid), 64'd0);
    check("rr_busy", 64'(busy16), 64'd0);
    check("rr_sum", 64'(if16.out_sum), 64'd0);
    check("rr_in_ready", 64'(if16.in_ready), 64'd1);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    d0 = done16;
    run_op16(16'h0001, 16'h0001, 1'b0, 1'b1);
    check("rr_next_done", 64'(done16 - d0), 64'd1);
    check("rr_next_sum", 64'(last_sum16), 64'h0003);
    check("rr_next_cout", 64'(last_cout16), 64'd0);

    // Random back-to-back on both widths
    d0 = done16;
    for (int k = 0; k < 600; k++) begin
      @(posedge clk); #1;
      if16.in_valid = 1'b1;
      if16.in_a = 16'($urandom); if16.in_b = 16'($urandom);
      if16.in_sub = 1'($urandom_range(0, 1)); if16.in_cin = 1'($urandom_range(0, 1));
      if16.out_ready = ($urandom_range(0, 3) != 0);
      if32.in_valid = 1'b1;
      if32.in_a = $urandom; if32.in_b = $urandom;
      if32.in_sub = 1'($urandom_range(0, 1)); if32.in_cin = 1'($urandom_range(0, 1));
      if32.out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    if16.in_valid = 1'b0; if16.out_ready = 1'b1;
    if32.in_valid = 1'b0; if32.out_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (exp16_q.size() == 0 && exp32_q.size() == 0 &&
          !if16.out_valid && !if32.out_valid && !busy16 && !busy32) break;
    end
    check("drain16_empty", 64'(exp16_q.size()), 64'd0);
    check("drain32_empty", 64'(exp32_q.size()), 64'd0);
    check("rand16_progress", 64'((done16 - d0) > 50), 64'd1);
    check("rand32_progress", 64'(done32 > 30), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
